icache_fill_ctrl: RTL and testbench
===================================

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge), rst_aL input 1 (sampled on clk only).
REQ-002 Parameter ADDR_WIDTH, default `ADDR_WIDTH (32), SHALL be the fetch/memory address width.
REQ-003 Parameter BLOCK_SIZE_BITS, default `ICACHE_DATA_BLOCK_SIZE (64), SHALL be the line width and memory beat width.
REQ-004 Fetch side SHALL be: req_valid in 1; req_ready out 1; req_addr in ADDR_WIDTH; resp_valid out 1; resp_ready in 1; resp_data out BLOCK_SIZE_BITS; resp_addr out ADDR_WIDTH; flush in 1 (abandon current fetch).
REQ-005 Cache side SHALL be: cache_addr out ADDR_WIDTH; cache_csb0 out 1 (active-low select); cache_we_aL out 1 (active-low write); cache_write_data out BLOCK_SIZE_BITS; cache_hit in 1; cache_rdata in BLOCK_SIZE_BITS (valid the cycle after a read select).
REQ-006 Memory side SHALL be: mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out ADDR_WIDTH (block-aligned, offset bits zero); mem_resp_valid in 1; mem_resp_data in BLOCK_SIZE_BITS.

Function
REQ-007 FSM states SHALL be IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid&req_ready; req_addr is latched into addr_q.
REQ-009 In the accept cycle cache_csb0=0, cache_we_aL=1, cache_addr=req_addr; next state LOOKUP.
REQ-010 In LOOKUP, cache_hit=1 SHALL latch cache_rdata into data_q and go to RESP; cache_hit=0 SHALL go to MISS_REQ.
REQ-011 Hit latency SHALL be 2 cycles: accept cycle 0, resp_valid=1 in cycle 2.
REQ-012 MISS_REQ SHALL hold mem_req_valid=1, mem_req_addr=addr_q block-aligned, until mem_req_ready=1, then go to MISS_WAIT.
REQ-013 MISS_WAIT SHALL wait for mem_resp_valid=1, latch mem_resp_data into data_q, go to FILL; mem_resp_valid in any other state SHALL be ignored.
REQ-014 FILL SHALL last exactly one cycle with cache_csb0=0, cache_we_aL=0, cache_addr=addr_q, cache_write_data=data_q (way choice stays inside cache); next state RESP.
REQ-015 RESP SHALL drive resp_valid=1, resp_data=data_q, resp_addr=addr_q, held stable until resp_ready=1, then IDLE; no new request accepted in the RESP cycle.
REQ-016 Outside REQ-009/REQ-014 cycles cache_csb0=1 and cache_we_aL=1.
REQ-017 flush in IDLE SHALL be ignored; in LOOKUP or RESP SHALL go to IDLE with no response; in MISS_REQ/MISS_WAIT/FILL SHALL set drop_q, complete the memory transaction and fill, then go to IDLE instead of RESP.
REQ-018 flush and req_valid together in IDLE SHALL accept the request.

Reset
REQ-019 rst_aL=0 at a clk edge SHALL force IDLE, drop_q=0, addr_q=0, data_q=0 from any state, including mid-miss (outstanding memory response is then ignored).
REQ-020 Reset output values: req_ready=1 after release, resp_valid=0, mem_req_valid=0, cache_csb0=1, cache_we_aL=1, all address/data outputs 0.

Configuration
REQ-021 Macro ICACHE_FILL_CTRL_PERF_EN defined SHALL add outputs perf_hit_cnt and perf_miss_cnt (32 bits each), incremented on LOOKUP hit/miss, saturating at all-ones, reset to 0.
REQ-022 Without ICACHE_FILL_CTRL_PERF_EN the ports and counters SHALL be absent and function SHALL be otherwise identical.

Structure
REQ-023 The state enum typedef and state encoding SHALL live in a shared package with the offset-bit count derived from BLOCK_SIZE_BITS.
REQ-024 The saturating counter SHALL be one sub-module, sat_cnt32, instantiated twice under the macro.

Verification
REQ-025 Hit: req_addr=0x0000_1040, cache_hit=1, cache_rdata=0xDEAD_BEEF_0123_4567 -> resp_valid in cycle 2 with that data, resp_addr=0x1040, no mem_req_valid.
REQ-026 Miss: req_addr=0x0000_2044, cache_hit=0, mem_req_ready after 3 cycles, mem_resp after 5 -> mem_req_addr=0x2040, one FILL cycle with we_aL=0, resp_data=mem_resp_data.
REQ-027 Backpressure: resp_ready=0 for 4 cycles in RESP -> resp_data/resp_addr stable, req_ready=0, then IDLE one cycle after resp_ready=1.
REQ-028 Flush in MISS_WAIT -> fill still written on mem_resp_valid, resp_valid never asserted, IDLE after FILL.
REQ-029 Reset asserted in MISS_WAIT, then mem_resp_valid pulse -> IDLE, no FILL, cache_we_aL stays 1.
REQ-030 With ICACHE_FILL_CTRL_PERF_EN: 3 hits and 2 misses -> perf_hit_cnt=3, perf_miss_cnt=2; counter preloaded to 0xFFFF_FFFF stays saturated.

Source files
------------

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types and helpers for the instruction-cache fill controller.
// Optional feature macro: ICACHE_FILL_CTRL_PERF_EN (hit/miss performance counters).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif

package icache_fill_ctrl_pkg;

    // Controller states; the encoding is fixed so debug traces stay comparable.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        FILL      = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam int unsigned DEFAULT_ADDR_WIDTH      = `ADDR_WIDTH;
    localparam int unsigned DEFAULT_BLOCK_SIZE_BITS = `ICACHE_DATA_BLOCK_SIZE;

    // Number of byte-offset bits inside one cache line of block_bits bits.
    function automatic int unsigned offset_bits(input int unsigned block_bits);
        return $clog2(block_bits / 8);
    endfunction

    localparam int unsigned DEFAULT_OFFSET_BITS = offset_bits(DEFAULT_BLOCK_SIZE_BITS);

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Fetch, cache-array and memory signals of the fill controller.
// master = the controller, slave = the surrounding fetch unit, array and memory.
//
// Handshake rule for every valid/ready pair (req, resp, mem_req): a transfer
// happens on a rising clk edge where valid and ready are both 1; once valid is
// raised, valid and its payload stay stable until that transfer. mem_resp_valid
// and cache_hit have no ready: they are single-cycle indications.
interface icache_fill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH      = `ADDR_WIDTH,
    parameter int unsigned BLOCK_SIZE_BITS = `ICACHE_DATA_BLOCK_SIZE
) ();
    logic                       req_valid;
    logic                       req_ready;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [BLOCK_SIZE_BITS-1:0] resp_data;
    logic [ADDR_WIDTH-1:0]      resp_addr;
    logic                       flush;

    logic [ADDR_WIDTH-1:0]      cache_addr;
    logic                       cache_csb0;
    logic                       cache_we_aL;
    logic [BLOCK_SIZE_BITS-1:0] cache_write_data;
    logic                       cache_hit;
    logic [BLOCK_SIZE_BITS-1:0] cache_rdata;

    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [ADDR_WIDTH-1:0]      mem_req_addr;
    logic                       mem_resp_valid;
    logic [BLOCK_SIZE_BITS-1:0] mem_resp_data;

    modport master (
        input  req_valid, req_addr, resp_ready, flush,
        input  cache_hit, cache_rdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, resp_addr,
        output cache_addr, cache_csb0, cache_we_aL, cache_write_data,
        output mem_req_valid, mem_req_addr
    );

    modport slave (
        output req_valid, req_addr, resp_ready, flush,
        output cache_hit, cache_rdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, resp_addr,
        input  cache_addr, cache_csb0, cache_we_aL, cache_write_data,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_fill_ctrl_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt32 (
    input  logic        clk,
    input  logic        rst_aL,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] cnt
);
    // Count register: load has priority, increments stop at saturation.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache fill controller: looks up one line per fetch, on a miss
// fetches the block from memory, writes it into the array, then responds.
// Optional feature macro: ICACHE_FILL_CTRL_PERF_EN adds perf_hit_cnt/perf_miss_cnt.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = `ADDR_WIDTH,
    parameter int unsigned BLOCK_SIZE_BITS = `ICACHE_DATA_BLOCK_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_aL,
    icache_fill_ctrl_if.master   bus,
`ifdef ICACHE_FILL_CTRL_PERF_EN
    output logic [31:0]          perf_hit_cnt,
    output logic [31:0]          perf_miss_cnt,
`endif
    output state_t               dbg_state
);
    localparam int unsigned OFS = offset_bits(BLOCK_SIZE_BITS);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [BLOCK_SIZE_BITS-1:0] data_q, data_d;
    logic                       drop_q, drop_d;

    logic                  req_ready, resp_valid, csb0, we_aL, mem_req_valid;
    logic [ADDR_WIDTH-1:0] cache_addr;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state and per-state outputs; a flushed miss still completes its fill.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        drop_d        = drop_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        csb0          = 1'b1;
        we_aL         = 1'b1;
        cache_addr    = '0;
        mem_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    drop_d     = 1'b0;
                    csb0       = 1'b0;
                    cache_addr = bus.req_addr;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.cache_hit) begin
                    data_d  = bus.cache_rdata;
                    state_d = RESP;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (bus.flush) drop_d = 1'b1;
                if (bus.mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (bus.flush) drop_d = 1'b1;
                if (bus.mem_resp_valid) begin
                    data_d  = bus.mem_resp_data;
                    state_d = FILL;
                end
            end
            FILL: begin
                csb0       = 1'b0;
                we_aL      = 1'b0;
                cache_addr = addr_q;
                state_d    = (drop_q || bus.flush) ? IDLE : RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.flush || bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready        = req_ready;
    assign bus.resp_valid       = resp_valid;
    assign bus.resp_data        = data_q;
    assign bus.resp_addr        = addr_q;
    assign bus.cache_addr       = cache_addr;
    assign bus.cache_csb0       = csb0;
    assign bus.cache_we_aL      = we_aL;
    assign bus.cache_write_data = data_q;
    assign bus.mem_req_valid    = mem_req_valid;
    assign bus.mem_req_addr     = addr_q & ~OFS_MASK;
    assign dbg_state            = state_q;

`ifdef ICACHE_FILL_CTRL_PERF_EN
    logic hit_evt, miss_evt;
    assign hit_evt  = (state_q == LOOKUP) && !bus.flush && bus.cache_hit;
    assign miss_evt = (state_q == LOOKUP) && !bus.flush && !bus.cache_hit;

    sat_cnt32 u_hit_cnt (
        .clk(clk), .rst_aL(rst_aL), .inc(hit_evt),
        .load(1'b0), .load_value(32'd0), .cnt(perf_hit_cnt)
    );
    sat_cnt32 u_miss_cnt (
        .clk(clk), .rst_aL(rst_aL), .inc(miss_evt),
        .load(1'b0), .load_value(32'd0), .cnt(perf_miss_cnt)
    );
`endif
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl.
// Optional feature macro: ICACHE_FILL_CTRL_PERF_EN enables the counter scenario.
module tb_icache_fill_ctrl;
    import icache_fill_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int BW = 64;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_aL = 1'b0;
    always #5 clk = ~clk;

    icache_fill_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_SIZE_BITS(BW)) bus ();
    state_t dbg_state;

`ifdef ICACHE_FILL_CTRL_PERF_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
    logic        sc_inc, sc_load;
    logic [31:0] sc_val, sc_cnt;
    sat_cnt32 u_sc (
        .clk(clk), .rst_aL(rst_aL), .inc(sc_inc),
        .load(sc_load), .load_value(sc_val), .cnt(sc_cnt)
    );
`endif

    icache_fill_ctrl #(.ADDR_WIDTH(AW), .BLOCK_SIZE_BITS(BW)) dut (
        .clk(clk),
        .rst_aL(rst_aL),
        .bus(bus),
`ifdef ICACHE_FILL_CTRL_PERF_EN
        .perf_hit_cnt(perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt),
`endif
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int fill_cnt = 0;
    int memreq_cnt = 0;

    // Scoreboard: expected response data and address, pushed when driven.
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    // Activity monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) resp_cnt++;
        if (bus.cache_csb0 === 1'b0 && bus.cache_we_aL === 1'b0) fill_cnt++;
        if (bus.mem_req_valid === 1'b1) memreq_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.resp_ready     = 1'b0;
        bus.flush          = 1'b0;
        bus.cache_hit      = 1'b0;
        bus.cache_rdata    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_aL = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        checks++;
        if ({bus.resp_valid, bus.mem_req_valid, bus.cache_csb0, bus.cache_we_aL} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0011",
                     {bus.resp_valid, bus.mem_req_valid, bus.cache_csb0, bus.cache_we_aL});
        end
        checks++;
        if ({bus.cache_addr, bus.mem_req_addr, bus.resp_addr, bus.resp_data, bus.cache_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_addr_data got=%0h/%0h/%0h/%0h/%0h exp=0", bus.cache_addr,
                     bus.mem_req_addr, bus.resp_addr, bus.resp_data, bus.cache_write_data);
        end
        step();
        rst_aL = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    // One complete fetch: hit or miss, memory latencies, response backpressure.
    task automatic do_txn(input logic [AW-1:0] addr, input bit hit, input logic [BW-1:0] data,
                          input int req_lat, input int resp_lat, input int bp, input string tag);
        int fc0, mc0;
        logic [AW-1:0] ea;
        logic [BW-1:0] ed;
        fc0 = fill_cnt;
        mc0 = memreq_cnt;
        step();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.cache_csb0, bus.cache_we_aL, bus.cache_addr} !== {3'b101, addr}) begin
            errors++;
            $display("FAIL %s_accept got=%b%b%b/%0h exp=101/%0h", tag, bus.req_ready,
                     bus.cache_csb0, bus.cache_we_aL, bus.cache_addr, addr);
        end
        step();
        bus.req_valid   = 1'b0;
        bus.cache_hit   = hit;
        bus.cache_rdata = hit ? data : {$urandom, $urandom};
        exp_addr_q.push_back(addr);
        if (hit) exp_q.push_back(data);
        step();
        bus.cache_hit = 1'b0;
        if (!hit) begin
            for (int i = 0; i <= req_lat; i++) begin
                if (i == req_lat) bus.mem_req_ready = 1'b1;
                @(negedge clk);
                checks++;
                if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, addr & 32'hFFFF_FFF8}) begin
                    errors++;
                    $display("FAIL %s_mem_req got=%b/%0h exp=1/%0h", tag, bus.mem_req_valid,
                             bus.mem_req_addr, addr & 32'hFFFF_FFF8);
                end
                step();
            end
            bus.mem_req_ready = 1'b0;
            repeat (resp_lat) step();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = data;
            exp_q.push_back(data);
            step();
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if ({bus.cache_csb0, bus.cache_we_aL, bus.cache_addr, bus.cache_write_data} !== {2'b00, addr, data}) begin
                errors++;
                $display("FAIL %s_fill got=%b%b/%0h/%0h exp=00/%0h/%0h", tag, bus.cache_csb0,
                         bus.cache_we_aL, bus.cache_addr, bus.cache_write_data, addr, data);
            end
            step();
        end
        if (exp_q.size() == 0 || exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard_empty got=0 exp=1", tag);
        end else begin
            ed = exp_q.pop_front();
            ea = exp_addr_q.pop_front();
            for (int i = 0; i <= bp; i++) begin
                if (i == bp) bus.resp_ready = 1'b1;
                @(negedge clk);
                checks++;
                if ({bus.resp_valid, bus.req_ready, bus.resp_data, bus.resp_addr} !== {2'b10, ed, ea}) begin
                    errors++;
                    $display("FAIL %s_resp got=%b%b/%0h/%0h exp=10/%0h/%0h", tag, bus.resp_valid,
                             bus.req_ready, bus.resp_data, bus.resp_addr, ed, ea);
                end
                step();
            end
        end
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s_idle got=%0d/%b exp=%0d/0", tag, dbg_state, bus.resp_valid, IDLE);
        end
        checks++;
        if ((fill_cnt - fc0) !== (hit ? 0 : 1) || (memreq_cnt - mc0) !== (hit ? 0 : req_lat + 1)) begin
            errors++;
            $display("FAIL %s_side_effects got=fill%0d/memreq%0d exp=fill%0d/memreq%0d", tag,
                     fill_cnt - fc0, memreq_cnt - mc0, hit ? 0 : 1, hit ? 0 : req_lat + 1);
        end
    endtask

    task automatic test_hit();
        do_txn(32'h0000_1040, 1'b1, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, "hit");
    endtask

    task automatic test_miss();
        do_txn(32'h0000_2044, 1'b0, 64'hCAFE_F00D_8899_AABB, 3, 5, 0, "miss");
    endtask

    task automatic test_backpressure();
        do_txn(32'h0000_1050, 1'b1, 64'h1111_2222_3333_4444, 0, 0, 4, "bp_hit");
        do_txn(32'h0000_4abc, 1'b0, 64'h5555_6666_7777_8888, 1, 2, 4, "bp_miss");
    endtask

    task automatic test_flush_lookup();
        int rc0;
        rc0 = resp_cnt;
        step();
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.req_addr  = 32'h0000_5000;
        @(negedge clk);
        checks++;
        if (bus.cache_csb0 !== 1'b0) begin
            errors++; $display("FAIL flush_idle_accept got=%b exp=0", bus.cache_csb0);
        end
        step();
        bus.req_valid   = 1'b0;
        bus.cache_hit   = 1'b1;
        bus.cache_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        step();
        bus.flush     = 1'b0;
        bus.cache_hit = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || resp_cnt !== rc0) begin
            errors++; $display("FAIL flush_lookup got=%0d/%0d exp=%0d/%0d", dbg_state, resp_cnt, IDLE, rc0);
        end
    endtask

    task automatic test_flush_miss();
        int rc0, fc0;
        rc0 = resp_cnt;
        fc0 = fill_cnt;
        step();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_3008;
        step();
        bus.req_valid = 1'b0;
        bus.cache_hit = 1'b0;
        step();
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h0123_4567_89AB_CDEF;
        step();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cache_we_aL, bus.cache_addr, bus.cache_write_data} !== {1'b0, 32'h0000_3008, 64'h0123_4567_89AB_CDEF}) begin
            errors++;
            $display("FAIL flush_miss_fill got=%b/%0h/%0h exp=0/3008/123456789abcdef",
                     bus.cache_we_aL, bus.cache_addr, bus.cache_write_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL flush_miss_idle got=%0d exp=%0d", dbg_state, IDLE);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_cnt !== rc0 || fill_cnt !== fc0 + 1) begin
            errors++;
            $display("FAIL flush_miss_counts got=resp%0d/fill%0d exp=resp%0d/fill%0d",
                     resp_cnt, fill_cnt, rc0, fc0 + 1);
        end
    endtask

    task automatic test_reset_miss();
        int fc0;
        fc0 = fill_cnt;
        step();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_6010;
        step();
        bus.req_valid = 1'b0;
        bus.cache_hit = 1'b0;
        step();
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        rst_aL = 1'b0;
        step();
        rst_aL = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hFFFF_0000_FFFF_0000;
        step();
        bus.mem_resp_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || bus.cache_we_aL !== 1'b1 || fill_cnt !== fc0) begin
            errors++;
            $display("FAIL reset_miss got=%0d/%b/fill%0d exp=%0d/1/fill%0d",
                     dbg_state, bus.cache_we_aL, fill_cnt, IDLE, fc0);
        end
        checks++;
        if ({bus.resp_addr, bus.mem_req_addr, bus.resp_data} !== '0) begin
            errors++;
            $display("FAIL reset_miss_regs got=%0h/%0h/%0h exp=0", bus.resp_addr, bus.mem_req_addr, bus.resp_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            do_txn($urandom, ($urandom_range(0, 1) == 1), {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2), "b2b");
        end
    endtask

`ifdef ICACHE_FILL_CTRL_PERF_EN
    task automatic test_perf();
        rst_aL = 1'b0;
        step();
        rst_aL = 1'b1;
        @(negedge clk);
        checks++;
        if (perf_hit_cnt !== 32'd0 || perf_miss_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_hit_cnt, perf_miss_cnt);
        end
        do_txn(32'h100, 1'b1, 64'h1, 0, 0, 0, "perf");
        do_txn(32'h208, 1'b0, 64'h2, 1, 1, 0, "perf");
        do_txn(32'h310, 1'b1, 64'h3, 0, 0, 1, "perf");
        do_txn(32'h418, 1'b0, 64'h4, 0, 2, 0, "perf");
        do_txn(32'h520, 1'b1, 64'h5, 0, 0, 0, "perf");
        checks++;
        if (perf_hit_cnt !== 32'd3 || perf_miss_cnt !== 32'd2) begin
            errors++; $display("FAIL perf_counts got=%0d/%0d exp=3/2", perf_hit_cnt, perf_miss_cnt);
        end
        sc_load = 1'b1;
        sc_val  = 32'hFFFF_FFFE;
        step();
        sc_load = 1'b0;
        sc_inc  = 1'b1;
        repeat (3) step();
        sc_inc = 1'b0;
        @(negedge clk);
        checks++;
        if (sc_cnt !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_from_fffffffe got=%0h exp=ffffffff", sc_cnt);
        end
        sc_load = 1'b1;
        sc_val  = 32'hFFFF_FFFF;
        step();
        sc_load = 1'b0;
        sc_inc  = 1'b1;
        repeat (2) step();
        sc_inc = 1'b0;
        @(negedge clk);
        checks++;
        if (sc_cnt !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_preloaded got=%0h exp=ffffffff", sc_cnt);
        end
    endtask
`endif

    initial begin
`ifdef ICACHE_FILL_CTRL_PERF_EN
        sc_inc  = 1'b0;
        sc_load = 1'b0;
        sc_val  = '0;
`endif
        test_reset();
        test_hit();
        test_miss();
        test_backpressure();
        test_flush_lookup();
        test_flush_miss();
        test_reset_miss();
        test_back_to_back();
`ifdef ICACHE_FILL_CTRL_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
